// File: rtl/fir_pkg.sv
// Shared constants and FSM state encoding for the folded 37-tap low-pass FIR.
package fir_pkg;
  localparam int TAP_NUM   = 37;
  localparam int IN_WL     = 15;
  localparam int MAC_WL    = 20;
  localparam int ADDR_W    = $clog2(TAP_NUM);
  localparam int ACC_WL    = 2 * IN_WL + ADDR_W;
  localparam int SCALE_LSB = 10;
  localparam int SCALE_MSB = SCALE_LSB + MAC_WL - 1;

  typedef enum logic [2:0] {
    ST_CLR,
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_OUT
  } state_t;
endpackage

// File: rtl/fir_mac_acc.sv
// Multiply-accumulate datapath with the output scaling stage.
// Build option FIR_SAT_EN: saturate on overflow instead of wrapping the slice.
module fir_mac_acc
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              load,
  input  logic [IN_WL-1:0]  a,
  input  logic [IN_WL-1:0]  b,
  output logic [MAC_WL-1:0] result
);
  logic signed [2*IN_WL-1:0] prod;
  logic        [ACC_WL-1:0]  acc_reg;
  logic        [ACC_WL-1:0]  acc_next;
  logic        [MAC_WL-1:0]  scaled;

  assign prod     = $signed(a) * $signed(b);
  assign acc_next = en ? acc_reg + {{(ACC_WL - 2*IN_WL){prod[2*IN_WL-1]}}, prod} : acc_reg;

  // Scaling looks at acc_next so the final product lands in the same cycle.
`ifdef FIR_SAT_EN
  always_comb begin
    scaled = acc_next[SCALE_MSB:SCALE_LSB];
    if (acc_next[ACC_WL-1:SCALE_MSB] != {(ACC_WL - SCALE_MSB){acc_next[SCALE_MSB]}})
      scaled = acc_next[ACC_WL-1] ? {1'b1, {(MAC_WL-1){1'b0}}} : {1'b0, {(MAC_WL-1){1'b1}}};
  end
`else
  assign scaled = acc_next[SCALE_MSB:SCALE_LSB];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      result  <= '0;
    end else begin
      if (clr) acc_reg <= '0;
      else     acc_reg <= acc_next;
      if (load) result <= scaled;
    end
  end
endmodule

// File: rtl/fir_fold_ctrl.sv
// Folded single-MAC FIR controller: sample-RAM clearing, write pointer, tap stepping,
// RAM/ROM address generation and the input/output handshakes.
module fir_fold_ctrl
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [IN_WL-1:0]  s_data,
  output logic              smp_we,
  output logic [ADDR_W-1:0] smp_waddr,
  output logic [IN_WL-1:0]  smp_wdata,
  output logic [ADDR_W-1:0] smp_raddr,
  input  logic [IN_WL-1:0]  smp_rdata,
  output logic [ADDR_W-1:0] coef_raddr,
  input  logic [IN_WL-1:0]  coef_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [MAC_WL-1:0] m_data
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAP_NUM - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] wp_reg;
  logic [ADDR_W-1:0] k_reg;
  logic              acc_en_reg;
  logic              accept;
  logic              clearing;

  assign accept   = s_ready && s_valid;
  assign clearing = (state_reg == ST_CLR);

  // Writes are suppressed while rst is held, even though the state already reads CLR.
  assign smp_we    = !rst && (clearing || accept);
  assign smp_waddr = clearing ? k_reg : wp_reg;
  assign smp_wdata = clearing ? '0 : s_data;

  // Newest sample sits at wp; tap k reads k samples back, wrapping below zero.
  assign smp_raddr  = (wp_reg >= k_reg) ? (wp_reg - k_reg) : (wp_reg + ADDR_W'(TAP_NUM) - k_reg);
  assign coef_raddr = k_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_CLR;
      wp_reg     <= '0;
      k_reg      <= '0;
      acc_en_reg <= 1'b0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
    end else begin
      // Read data returns one cycle after each MAC address, so accumulation lags by one.
      acc_en_reg <= (state_reg == ST_MAC);
      case (state_reg)
        ST_CLR: begin
          if (k_reg == LAST) begin
            k_reg     <= '0;
            s_ready   <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        ST_IDLE: begin
          if (s_valid) begin
            s_ready   <= 1'b0;
            k_reg     <= '0;
            state_reg <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (k_reg == LAST) state_reg <= ST_DRAIN;
          else               k_reg     <= k_reg + 1'b1;
        end
        ST_DRAIN: begin
          m_valid   <= 1'b1;
          state_reg <= ST_OUT;
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid   <= 1'b0;
            s_ready   <= 1'b1;
            wp_reg    <= (wp_reg == LAST) ? '0 : wp_reg + 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_CLR;
      endcase
    end
  end

  fir_mac_acc u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (acc_en_reg),
    .load   (state_reg == ST_DRAIN),
    .a      (smp_rdata),
    .b      (coef_rdata),
    .result (m_data)
  );
endmodule

// File: tb/tb_fir_fold_ctrl.sv
// Randomized self-checking bench for fir_fold_ctrl against a convolution-level model.
module tb_fir_fold_ctrl;
  import fir_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [IN_WL-1:0]  s_data = '0;
  logic              smp_we;
  logic [ADDR_W-1:0] smp_waddr;
  logic [IN_WL-1:0]  smp_wdata;
  logic [ADDR_W-1:0] smp_raddr;
  logic [IN_WL-1:0]  smp_rdata;
  logic [ADDR_W-1:0] coef_raddr;
  logic [IN_WL-1:0]  coef_rdata;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [MAC_WL-1:0] m_data;

  logic [IN_WL-1:0]  ram [64];
  logic [IN_WL-1:0]  rom [64];

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     clr_left = 0;
  int     model_wp = 0;
  int     hist[$];
  longint exp_q[$];
  int     acc_cyc_q[$];
  longint got[$];
  bit     prev_hold = 0;
  logic [MAC_WL-1:0] prev_mdata = '0;
  bit     rand_rdy = 0;

  fir_fold_ctrl dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .smp_we(smp_we), .smp_waddr(smp_waddr), .smp_wdata(smp_wdata),
    .smp_raddr(smp_raddr), .smp_rdata(smp_rdata),
    .coef_raddr(coef_raddr), .coef_rdata(coef_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  always #5 clk = ~clk;

  // External synchronous-read sample RAM and coefficient ROM
  always @(posedge clk) begin
    if (smp_we) ram[smp_waddr] <= smp_wdata;
    smp_rdata  <= ram[smp_raddr];
    coef_rdata <= rom[coef_raddr];
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint scale_model(input longint s);
    longint w;
`ifdef FIR_SAT_EN
    if (s > 64'sd536870911)  return 524287;
    if (s < -64'sd536870912) return -524288;
`endif
    w = (s >>> 10) & 64'hFFFFF;
    if (w >= 524288) w = w - 1048576;
    return w;
  endfunction

  // y[n] = scale( sum_j coef[j] * x[n-j] ), x before the last reset = 0
  function automatic longint model_out();
    longint sum = 0;
    for (int j = 0; j < TAP_NUM; j++) begin
      int idx = hist.size() - 1 - j;
      if (idx >= 0) sum += longint'($signed(rom[j])) * longint'(hist[idx]);
    end
    return scale_model(sum);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_smp_we", smp_we, 0);
      clr_left = TAP_NUM;
      model_wp = 0;
      hist.delete();
      exp_q.delete();
      acc_cyc_q.delete();
      prev_hold = 0;
    end else begin
      if (clr_left > 0) begin
        chk("clr_we", smp_we, 1);
        chk("clr_waddr", smp_waddr, TAP_NUM - clr_left);
        chk("clr_wdata", smp_wdata, 0);
        chk("clr_s_ready", s_ready, 0);
        chk("clr_m_valid", m_valid, 0);
        clr_left--;
      end else begin
        chk("we", smp_we, s_valid && s_ready);
        if (s_valid && s_ready) begin
          chk("waddr", smp_waddr, model_wp);
          chk("wdata", smp_wdata, s_data);
          hist.push_back(int'($signed(s_data)));
          exp_q.push_back(model_out());
          acc_cyc_q.push_back(cyc);
        end
      end
      if (m_valid) begin
        chk("overlap_s_ready", s_ready, 0);
        if (!prev_hold) begin
          if (acc_cyc_q.size() == 0) begin
            failures++; checks++;
            $display("FAIL unexpected_m_valid: got 1 expected 0 (t=%0t)", $time);
          end else begin
            chk("latency", cyc - acc_cyc_q[0], TAP_NUM + 2);
          end
        end else begin
          chk("hold_m_data", m_data, prev_mdata);
        end
        if (m_ready && exp_q.size() > 0) begin
          chk("m_data", $signed(m_data), exp_q.pop_front());
          got.push_back($signed(m_data));
          void'(acc_cyc_q.pop_front());
          model_wp = (model_wp + 1) % TAP_NUM;
        end
      end
      prev_hold  = m_valid && !m_ready;
      prev_mdata = m_data;
    end
  end

  task automatic send(input logic [IN_WL-1:0] x);
    int t = 0;
    s_data  = x;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      failures++; checks++;
      $display("FAIL send_timeout: got no s_ready expected s_ready within 200 cycles");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !s_ready) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) begin
      failures++; checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    longint exp_hi, exp_lo;
    int n0, seen, t;
    for (int j = 0; j < 64; j++) rom[j] = 15'($urandom);

    // Reset and RAM clear
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (TAP_NUM) @(posedge clk);
    #1;
    chk("clr_done_s_ready", s_ready, 1);

    // Impulse of -16384 with negated coefficients gives coef*16 from the original ROM
    rom[0] = 15'sd38; rom[1] = 15'sd137; rom[2] = 15'sd0; rom[3] = -15'sd241; rom[18] = -15'sd16383;
    m_ready = 1'b1;
    got.delete();
    send(15'h4000);
    for (int i = 1; i < TAP_NUM; i++) send('0);
    drain();
    chk("imp_count", got.size(), TAP_NUM);
    if (got.size() >= 19) begin
      chk("imp_0", got[0], -608);
      chk("imp_1", got[1], -2192);
      chk("imp_2", got[2], 0);
      chk("imp_3", got[3], 3856);
      chk("imp_18", got[18], 262128);
    end

    // Random coefficients, samples, gaps and backpressure (wraps wp several times)
    for (int j = 0; j < TAP_NUM; j++) rom[j] = 15'($urandom);
    rand_rdy = 1;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      send(15'($urandom));
    end
    drain();
    rand_rdy = 0;
    #1;

    // Backpressure held for 10 cycles in OUT
    m_ready = 1'b0;
    send(15'($urandom));
    t = 0;
    while (!m_valid && t < 100) begin @(posedge clk); #1; t++; end
    repeat (10) begin @(posedge clk); #1; end
    chk("bp_valid_held", m_valid, 1);
    chk("bp_s_ready", s_ready, 0);
    n0 = got.size();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_one_handshake", got.size(), n0 + 1);
    chk("bp_valid_low", m_valid, 0);
    m_ready = 1'b1;
    drain();

    // Saturation / wrap with a full-scale window
`ifdef FIR_SAT_EN
    exp_hi = 524287;  exp_lo = -524288;
`else
    exp_hi = 260960;  exp_lo = -261552;
`endif
    chk("model_pin_hi", scale_model(64'sd37 * 16383 * 16383), exp_hi);
    chk("model_pin_lo", scale_model(-64'sd37 * 16383 * 16384), exp_lo);
    for (int j = 0; j < TAP_NUM; j++) rom[j] = 15'sd16383;
    got.delete();
    for (int i = 0; i < TAP_NUM; i++) send(15'sd16383);
    drain();
    chk("sat_hi", (got.size() >= TAP_NUM) ? got[TAP_NUM-1] : 64'sd99999999, exp_hi);
    got.delete();
    for (int i = 0; i < TAP_NUM; i++) send(-15'sd16384);
    drain();
    chk("sat_lo", (got.size() >= TAP_NUM) ? got[TAP_NUM-1] : 64'sd99999999, exp_lo);

    // Reset in the middle of MAC
    for (int j = 0; j < TAP_NUM; j++) rom[j] = 15'($urandom);
    send(15'($urandom));
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (TAP_NUM + 3) begin
      @(posedge clk); #1;
      if (m_valid) seen++;
    end
    chk("rstmac_no_valid", seen, 0);
    chk("rstmac_s_ready", s_ready, 1);
    s_data  = 15'($urandom);
    s_valid = 1'b1;
    @(negedge clk);
    chk("rstmac_we", smp_we, 1);
    chk("rstmac_waddr", smp_waddr, 0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
